// File: rtl/memr_word_loader.sv
// -----------------------------------------------------------------------------
// memr_word_loader
//
// Write-side feeder for the wide-word vector memory. Elements arrive over a
// valid/ready handshake and are packed no_of_units at a time into one memory
// word, lowest lane first. Each packed word is written at sequential word
// addresses starting at 0. When the programmed number of words has been
// written, finish is raised and held until the next accepted start or reset.
//
// Optional build macro: MEMR_LOADER_CHECKSUM_EN
//   When defined, adds output 'checksum': the running modulo-2^element_width
//   sum of every element accepted in the current job.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   start             single-cycle job start; honoured only in IDLE or DONE
//   num_words         words to write; sampled on accepted start, clamped to
//                     memory_height+1
//   in_data           element payload
//   in_valid          element present
//   in_ready          loader can accept an element this cycle
//   mem_write_data    packed word (holds last value while not writing)
//   mem_write_enable  one-cycle write strobe
//   mem_write_address word address of the current write
//   busy              job in progress (FILL or WRITE)
//   finish            job complete
//   checksum          (MEMR_LOADER_CHECKSUM_EN only) running element sum
// -----------------------------------------------------------------------------
module memr_word_loader #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int memory_height = 1000,
    parameter int address_width = $clog2(memory_height) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [address_width-1:0]             num_words,
    input  logic [element_width-1:0]             in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [no_of_units*element_width-1:0] mem_write_data,
    output logic                                 mem_write_enable,
    output logic [address_width-1:0]             mem_write_address,
    output logic                                 busy,
    output logic                                 finish
`ifdef MEMR_LOADER_CHECKSUM_EN
    ,
    output logic [element_width-1:0]             checksum
`endif
);

    localparam int word_width = no_of_units * element_width;
    localparam int lane_width = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam logic [address_width-1:0] max_words = address_width'(memory_height + 1);
    localparam logic [lane_width-1:0]    last_lane = lane_width'(no_of_units - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t                   state;
    logic [lane_width-1:0]    lane_count;
    logic [address_width-1:0] word_count;
    logic [address_width-1:0] word_target;
    logic [address_width-1:0] word_count_next;
    logic [word_width-1:0]    pack_reg;
    logic [word_width-1:0]    pack_next;
    logic                     accept;

    assign accept          = (state == FILL) && in_valid && in_ready;
    assign word_count_next = word_count + 1'b1;

    // Packed word including the element offered this cycle, so the last lane
    // can go straight to mem_write_data on the same edge it is accepted.
    always_comb begin
        pack_next = pack_reg;
        pack_next[int'(lane_count) * element_width +: element_width] = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            in_ready          <= 1'b0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            busy              <= 1'b0;
            finish            <= 1'b0;
            lane_count        <= '0;
            word_count        <= '0;
            word_target       <= '0;
            pack_reg          <= '0;
`ifdef MEMR_LOADER_CHECKSUM_EN
            checksum          <= '0;
`endif
        end else begin
            mem_write_enable <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        word_target <= (num_words > max_words) ? max_words : num_words;
                        word_count  <= '0;
                        lane_count  <= '0;
                        finish      <= 1'b0;
`ifdef MEMR_LOADER_CHECKSUM_EN
                        checksum    <= '0;
`endif
                        if (num_words == '0) begin
                            state  <= DONE;
                            finish <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        pack_reg <= pack_next;
`ifdef MEMR_LOADER_CHECKSUM_EN
                        checksum <= checksum + in_data;
`endif
                        if (lane_count == last_lane) begin
                            state             <= WRITE;
                            in_ready          <= 1'b0;
                            mem_write_enable  <= 1'b1;
                            mem_write_data    <= pack_next;
                            mem_write_address <= word_count;
                        end else begin
                            lane_count <= lane_count + 1'b1;
                        end
                    end
                end

                WRITE: begin
                    word_count <= word_count_next;
                    lane_count <= '0;
                    if (word_count_next == word_target) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memr_word_loader.sv
// -----------------------------------------------------------------------------
// tb_memr_word_loader
//
// Self-checking bench for memr_word_loader. Each job records every element
// that completes a handshake and every write strobe; the expected write
// stream is rebuilt from the accepted-element list (word w = elements
// w*U .. w*U+U-1, lowest lane first, address w). Strobe timing, in_ready
// during writes, busy/finish and the optional checksum are also checked.
// -----------------------------------------------------------------------------
module tb_memr_word_loader;

    localparam int EW = 32;
    localparam int U  = 8;
    localparam int MH = 1000;
    localparam int AW = $clog2(MH) + 1;
    localparam int DW = EW * U;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] num_words;
    logic [EW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_address;
    logic          busy;
    logic          finish;
`ifdef MEMR_LOADER_CHECKSUM_EN
    logic [EW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    memr_word_loader #(
        .element_width (EW),
        .no_of_units   (U),
        .memory_height (MH),
        .address_width (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .num_words         (num_words),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mem_write_data    (mem_write_data),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .busy              (busy),
        .finish            (finish)
`ifdef MEMR_LOADER_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] acc[$];
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_word(input int base);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < U; k++)
            w = w | (DW'(acc[base + k]) << (k * EW));
        return w;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},  in_ready, 0);
        check({tag, "_we"},   mem_write_enable, 0);
        check({tag, "_addr"}, mem_write_address, 0);
        check({tag, "_data"}, mem_write_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fin"},  finish, 0);
`ifdef MEMR_LOADER_CHECKSUM_EN
        check({tag, "_csum"}, checksum, 0);
`endif
    endtask

    // vmode: 0 valid always, 1 valid every other cycle, 2 random valid
    // dmode: 0 random data, 1 sequential 1,2,3..., 2 all ones
    task automatic run_job(input int n, input int vmode, input int dmode, input bit midstart);
        int  neff;
        int  budget;
        int  cyc;
        bit  hs;
        bit  done;
        bit  mid_done;
        logic [EW-1:0] sum;
        neff = (n > MH + 1) ? MH + 1 : n;
        budget = neff * (U + 1) * 6 + 20;
        acc.delete();
        wr_addr.delete();
        wr_data.delete();
        mid_done = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        num_words = AW'(n);
        in_valid  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, neff != 0);
        if (neff != 0) check("start_fin", finish, 0);

        if (neff == 0) begin
            @(negedge clk);
            @(posedge clk); #1;
            check("zero_fin", finish, 1);
            check("zero_busy", busy, 0);
            check("zero_we", mem_write_enable, 0);
        end else begin
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < budget) begin
                @(negedge clk);
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = cyc[0];
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                case (dmode)
                    1:       in_data = EW'(acc.size() + 1);
                    2:       in_data = '1;
                    default: in_data = $urandom;
                endcase
                if (midstart && !mid_done && in_ready && acc.size() == 3) begin
                    start     = 1'b1;
                    num_words = AW'(7);
                    mid_done  = 1'b1;
                end
                hs = in_valid && in_ready;
                if (hs) acc.push_back(in_data);
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
                check("we_timing", mem_write_enable, hs && (acc.size() % U == 0));
                if (mem_write_enable) begin
                    check("rdy_in_write", in_ready, 0);
                    wr_addr.push_back(mem_write_address);
                    wr_data.push_back(mem_write_data);
                end
                check("busy_vs_fin", busy, !finish);
                done = finish;
            end
            if (!done) check("job_timeout", 0, 1);
        end

        check("elem_count", acc.size(), neff * U);
        check("write_count", wr_addr.size(), neff);
        for (int w = 0; w < wr_addr.size() && w < neff; w++) begin
            check("wr_addr", wr_addr[w], w);
            if (acc.size() >= (w + 1) * U) check("wr_data", wr_data[w], pack_word(w * U));
        end
`ifdef MEMR_LOADER_CHECKSUM_EN
        sum = '0;
        foreach (acc[i]) sum = sum + acc[i];
        check("checksum", checksum, sum);
`endif

        // In DONE, offered elements are never consumed and nothing is written.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
            check("done_rdy", in_ready, 0);
            check("done_we", mem_write_enable, 0);
            check("done_fin", finish, 1);
            check("done_busy", busy, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [DW-1:0] first_word;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_words = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single word, elements 1..8 back-to-back.
        run_job(1, 0, 1, 1'b0);
        first_word = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        if (wr_data.size() > 0) check("first_word", wr_data[0], first_word);
        else check("first_word_missing", 0, 1);

        // Three words with valid toggling.
        run_job(3, 1, 1, 1'b0);

        // Zero-word job.
        run_job(0, 0, 0, 1'b0);

        // Reset after five elements of a two-word job.
        @(negedge clk);
        start     = 1'b1;
        num_words = AW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hDEAD_0000 + i;
            @(posedge clk); #1;
            check("pre_reset_we", mem_write_enable, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_we", mem_write_enable, 0);
        run_job(1, 0, 1, 1'b0);

        // Start pulsed mid-FILL is ignored, then restart from DONE.
        run_job(2, 0, 0, 1'b1);
        run_job(2, 2, 0, 1'b0);

        // All-ones elements: checksum wraps.
        run_job(1, 0, 2, 1'b0);
`ifdef MEMR_LOADER_CHECKSUM_EN
        check("csum_ones", checksum, 32'hFFFF_FFF8);
`endif

        // Randomised jobs.
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 4), $urandom_range(0, 2), 0, 1'b0);

        // Oversized request clamps to memory_height+1 words.
        run_job(2047, 0, 0, 1'b0);
        if (wr_addr.size() > 0) check("clamp_last_addr", wr_addr[wr_addr.size() - 1], MH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
